// File: rtl/code_port_arbiter_pkg.sv
// Shared definitions for the code RAM port arbiter.
//   acc_state_e : debug access sequencer state (IDLE -> PEND -> RESP).
package code_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no debug access in flight
        ST_PEND = 2'd1,  // request latched, waiting for a cycle without a taken branch
        ST_RESP = 2'd2   // RAM has been accessed, acknowledge this cycle
    } acc_state_e;

endpackage

// File: rtl/code_port_arbiter.sv
// Code RAM port arbiter: shares the single-port synchronous code RAM between
// the fetch stage and the debug/loader port, and gives the debugger
// halt / single-step control over fetch.
//
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   fetch_addr          : instruction address from the fetch stage
//   call_performed      : taken branch/call this cycle, fetch must not stall
//   fetch_stall         : to fetch stage no_operation (combinational)
//   dbg_req/we/addr/wdata : level debug request, held until dbg_ack
//   dbg_ack, dbg_rdata  : one-cycle completion pulse and read data (0 otherwise)
//   dbg_halt, dbg_step  : halt level, single-step pulse
//   halted              : fetch is halted
//   mem_addr/we/wdata   : RAM request, mem_rdata has one cycle latency
module code_port_arbiter
    import code_port_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE    = 18,
    parameter int WORD_SIZE    = 18,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] fetch_addr,
    input  logic                 call_performed,
    output logic                 fetch_stall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [ADDR_SIZE-1:0] dbg_addr,
    input  logic [WORD_SIZE-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [WORD_SIZE-1:0] dbg_rdata,
    input  logic                 dbg_halt,
    input  logic                 dbg_step,
    output logic                 halted,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    acc_state_e           state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 halted_q, halted_d;
    logic                 step_pending_q, step_pending_d;

    logic access_cycle;
    logic step_go;

    // A taken branch always keeps the port: the access waits in PEND.
    assign access_cycle = (state_q == ST_PEND) && !call_performed;

    // A pending debug access wins over a pending step; the step simply
    // fires on the next cycle the port is free.
    assign step_go = halted_q && step_pending_q && !access_cycle;

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        halted_d       = halted_q;
        step_pending_d = step_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (dbg_req) begin
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!call_performed) begin
                    state_d = ST_RESP;
                end
            end
            // dbg_req is still the just-served request here, so it is ignored.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Halt entry is deferred while a branch is being taken so the branch
        // target is fetched before fetch freezes.
        if (!dbg_halt) begin
            halted_d = 1'b0;
        end else if (!call_performed) begin
            halted_d = 1'b1;
        end

        step_pending_d = (step_pending_q && !step_go) || (dbg_step && halted_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            halted_q       <= RESET_HALTED;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            halted_q       <= halted_d;
            step_pending_q <= step_pending_d;
        end
    end

    // The only call_performed -> output path; a branch is never dropped,
    // not even while halted.
    assign fetch_stall = !call_performed && (access_cycle || (halted_q && !step_go));

    assign mem_addr  = access_cycle ? addr_q : fetch_addr;
    assign mem_we    = access_cycle && we_q;
    assign mem_wdata = wdata_q;

    // RESP is the cycle after the RAM access, so mem_rdata already holds
    // the addressed word.
    assign dbg_ack   = (state_q == ST_RESP);
    assign dbg_rdata = (dbg_ack && !we_q) ? mem_rdata : '0;
    assign halted    = halted_q;

endmodule

// File: doc/code_port_arbiter.md
# code_port_arbiter

Shares the single-port synchronous code RAM between the fetch stage and the debug/loader port, and provides halt/single-step control of fetch. Sits between the fetch stage, the code RAM and the debug UART bridge. It drives the fetch stage's stall input so a debug access or a halt freezes the instruction pointer without losing a taken branch. Debug reads and writes complete with a one-cycle acknowledge pulse.

## Interface
- ADDR_SIZE, 18, code address width
- WORD_SIZE, 18, code word width
- RESET_HALTED, 0, value of `halted` after reset (1 = hold fetch until the loader resumes)

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fetch_addr  in  ADDR_SIZE  instruction address from fetch stage
- call_performed  in  1  taken branch/call this cycle; fetch must not be stalled
- fetch_stall  out  1  to fetch stage no_operation; combinational
- dbg_req  in  1  level request, held with fields stable until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_SIZE  debug address
- dbg_wdata  in  WORD_SIZE  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  WORD_SIZE  read data, valid with dbg_ack, else 0
- dbg_halt  in  1  level: 1 = halt fetch, 0 = run
- dbg_step  in  1  pulse: allow one fetch advance while halted
- halted  out  1  fetch is halted
- mem_addr  out  ADDR_SIZE  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  WORD_SIZE  RAM write data
- mem_rdata  in  WORD_SIZE  RAM read data, 1-cycle latency

## Operation
- Access FSM: IDLE, PEND, RESP.
  - IDLE: if dbg_req=1, latch we/addr/wdata and go to PEND.
  - PEND: if call_performed=0, this is the access cycle: mem_addr=latched addr, mem_we=latched we, fetch_stall=1, next state RESP. If call_performed=1, fetch owns the port and the FSM stays in PEND.
  - RESP: dbg_ack=1; dbg_rdata=mem_rdata for reads, 0 for writes; next state IDLE. dbg_req is ignored in RESP because it is still the old request.
- Outside the access cycle: mem_addr=fetch_addr, mem_we=0, mem_wdata=latched wdata.
- halted register:
  - Sets on an edge where dbg_halt=1 and call_performed=0.
  - Clears on an edge where dbg_halt=0.
- step_pending register:
  - Sets on dbg_step while halted; ignored when not halted.
  - Clears on the step_go cycle.
  - step_go = halted & step_pending & not(access cycle).
- fetch_stall = !call_performed & (access cycle | (halted & !step_go)). A branch is therefore never dropped, including while halted.
- Priority: pending debug access over step.

## Timing
- Reset values: FSM IDLE, dbg_ack=0, dbg_rdata=0, mem_we=0, halted=RESET_HALTED, step_pending=0. fetch_stall=RESET_HALTED.
- Access latency: req seen at cycle 0, access cycle at 1 (later if call_performed), ack at 2.
  - Peak throughput is one access per 3 cycles.
  - Fetch runs in cycles 0 and 2.
- Halt takes effect the cycle after dbg_halt is sampled; resume likewise.
- Step: exactly one unstalled fetch cycle, no earlier than the cycle after the dbg_step pulse.
- Reset mid-access drops the request with no ack; the loader reissues it.
- dbg_halt and call_performed in the same cycle: halt entry slips one cycle.

## Structure
- Shared package holds the FSM state encoding (IDLE/PEND/RESP, 2 bits).
- Single module, no sub-module.
- fetch_stall is the only combinational output path (call_performed → fetch enable); it is constrained as such.

## Test plan
- Running, dbg read addr 0x10 (RAM holds 0x2ABCD) → fetch_stall=1 for exactly one cycle, dbg_ack at cycle 2 with dbg_rdata=0x2ABCD, fetch address held across the stall.
- dbg write 0x00123 to 0x05, then read 0x05 → second ack returns 0x00123; mem_we high for exactly one cycle.
- call_performed=1 during the PEND cycle → access slips one cycle, fetch_stall=0 that cycle, ack at cycle 3.
- dbg_halt=1 → halted=1 next cycle, fetch_stall held high; three dbg_step pulses → exactly three single-cycle fetch advances.
- Halted with call_performed=1 → fetch_stall=0 that cycle, fetch address follows the branch target.
- RESET_HALTED=1: after reset halted=1; load 4 words, set dbg_halt=0 → fetch starts from address 0. Reset asserted in PEND → no ack, FSM IDLE.
